// File: rtl/tx_trn_arbiter_pkg.sv
// Shared TRN TX definitions: idle values for the core-facing bus and arbiter state codes.
package tx_trn_arbiter_pkg;

  localparam int TRN_D_W   = 64;
  localparam int TRN_REM_W = 8;

  localparam logic [TRN_D_W-1:0]   TRN_TD_IDLE   = '0;
  localparam logic [TRN_REM_W-1:0] TRN_TREM_IDLE = 8'hFF;

  typedef enum logic [2:0] {
    ARB_S_OFFER = 3'b001,
    ARB_S_OWNED = 3'b010,
    ARB_S_GAP   = 3'b100
  } arb_state_e;

endpackage

// File: rtl/tx_trn_arbiter_if.sv
// Requester-side handshake plus the shared TRN TX bus toward the PCIe core.
interface tx_trn_arbiter_if
  import tx_trn_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]           driving_interface;
  logic [NUM_REQ-1:0]           my_turn;
  logic [NUM_REQ*TRN_D_W-1:0]   req_trn_td;
  logic [NUM_REQ*TRN_REM_W-1:0] req_trn_trem_n;
  logic [NUM_REQ-1:0]           req_trn_tsof_n;
  logic [NUM_REQ-1:0]           req_trn_teof_n;
  logic [NUM_REQ-1:0]           req_trn_tsrc_rdy_n;
  logic [NUM_REQ-1:0]           req_cfg_interrupt_n;

  logic [TRN_D_W-1:0]           trn_td;
  logic [TRN_REM_W-1:0]         trn_trem_n;
  logic                         trn_tsof_n;
  logic                         trn_teof_n;
  logic                         trn_tsrc_rdy_n;
  logic                         cfg_interrupt_n;

  // Arbiter side
  modport slave (
    input  driving_interface, req_trn_td, req_trn_trem_n, req_trn_tsof_n,
           req_trn_teof_n, req_trn_tsrc_rdy_n, req_cfg_interrupt_n,
    output my_turn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n,
           trn_tsrc_rdy_n, cfg_interrupt_n
  );

  // Requester engines and core side
  modport master (
    output driving_interface, req_trn_td, req_trn_trem_n, req_trn_tsof_n,
           req_trn_teof_n, req_trn_tsrc_rdy_n, req_cfg_interrupt_n,
    input  my_turn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n,
           trn_tsrc_rdy_n, cfg_interrupt_n
  );
endinterface

// File: rtl/tx_trn_arbiter_mux.sv
// NUM_REQ-way combinational TRN TX select; drives idle values whenever nobody owns the bus.
module trn_tx_mux
  import tx_trn_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [IDX_W-1:0]             sel,
  input  logic                         sel_valid,
  input  logic [NUM_REQ*TRN_D_W-1:0]   req_td,
  input  logic [NUM_REQ*TRN_REM_W-1:0] req_trem_n,
  input  logic [NUM_REQ-1:0]           req_tsof_n,
  input  logic [NUM_REQ-1:0]           req_teof_n,
  input  logic [NUM_REQ-1:0]           req_tsrc_rdy_n,
  input  logic [NUM_REQ-1:0]           req_cfg_interrupt_n,
  output logic [TRN_D_W-1:0]           td,
  output logic [TRN_REM_W-1:0]         trem_n,
  output logic                         tsof_n,
  output logic                         teof_n,
  output logic                         tsrc_rdy_n,
  output logic                         cfg_interrupt_n
);

  always_comb begin
    td              = TRN_TD_IDLE;
    trem_n          = TRN_TREM_IDLE;
    tsof_n          = 1'b1;
    teof_n          = 1'b1;
    tsrc_rdy_n      = 1'b1;
    cfg_interrupt_n = 1'b1;
    // Compare against each legal index so an unused sel code can never reach past NUM_REQ
    if (sel_valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sel == IDX_W'(i)) begin
          td              = req_td[TRN_D_W*i +: TRN_D_W];
          trem_n          = req_trem_n[TRN_REM_W*i +: TRN_REM_W];
          tsof_n          = req_tsof_n[i];
          teof_n          = req_teof_n[i];
          tsrc_rdy_n      = req_tsrc_rdy_n[i];
          cfg_interrupt_n = req_cfg_interrupt_n[i];
        end
      end
    end
  end

endmodule

// File: rtl/tx_trn_arbiter.sv
// Round-robin owner of the single PCIe TRN TX interface: turn offering, ownership tracking,
// sticky protocol/hold-timeout flags, and a zero-latency output mux.
module tx_trn_arbiter
  import tx_trn_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int IDX_W       = 2,
  parameter int TURN_WINDOW = 4,
  parameter int HOLD_MAX    = 1024
) (
  input  logic              trn_clk,
  input  logic              reset_n,
  tx_trn_arbiter_if.slave   bus,
  output logic              owner_valid,
  output logic [IDX_W-1:0]  owner_idx,
  output logic              err_protocol,
  output logic              err_hold_timeout
);

  localparam int WIN_W  = (TURN_WINDOW > 2) ? $clog2(TURN_WINDOW) : 1;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_idx_q, owner_idx_d;
  logic               owner_valid_q, owner_valid_d;
  logic [NUM_REQ-1:0] my_turn_q, my_turn_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               err_protocol_q, err_protocol_d;
  logic               err_hold_q, err_hold_d;

  logic [NUM_REQ-1:0] drv, ptr_oh, owner_oh;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    idx_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    next_idx = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign drv      = bus.driving_interface;
  assign ptr_oh   = idx_onehot(ptr_q);
  assign owner_oh = idx_onehot(owner_idx_q);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_idx_d    = owner_idx_q;
    owner_valid_d  = owner_valid_q;
    win_cnt_d      = win_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    err_protocol_d = err_protocol_q;
    err_hold_d     = err_hold_q;
    my_turn_d      = '0;
    unique case (state_q)
      ARB_S_OFFER: begin
        if ((drv & ~ptr_oh) != '0) err_protocol_d = 1'b1;
        // A claim beats window expiry in the same cycle
        if ((drv & ptr_oh) != '0) begin
          owner_idx_d   = ptr_q;
          owner_valid_d = 1'b1;
          win_cnt_d     = '0;
          hold_cnt_d    = '0;
          state_d       = ARB_S_OWNED;
        end else if (my_turn_q != '0) begin
          // The window only runs while the offer is visible (not in the first cycle out of reset)
          if (win_cnt_q == WIN_W'(TURN_WINDOW - 1)) begin
            ptr_d     = next_idx(ptr_q);
            win_cnt_d = '0;
            state_d   = ARB_S_GAP;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
      end
      ARB_S_OWNED: begin
        if ((drv & ~owner_oh) != '0) err_protocol_d = 1'b1;
        if (hold_cnt_q == HOLD_W'(HOLD_MAX)) err_hold_d = 1'b1;
        if ((drv & owner_oh) == '0) begin
          owner_valid_d = 1'b0;
          ptr_d         = next_idx(owner_idx_q);
          hold_cnt_d    = '0;
          state_d       = ARB_S_GAP;
        end else if (hold_cnt_q != HOLD_W'(HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ARB_S_GAP: begin
        if (drv != '0) err_protocol_d = 1'b1;
        state_d = ARB_S_OFFER;
      end
      default: begin
        owner_valid_d = 1'b0;
        state_d       = ARB_S_OFFER;
      end
    endcase
    if (state_d == ARB_S_OFFER) my_turn_d = idx_onehot(ptr_d);
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ARB_S_OFFER;
      ptr_q          <= '0;
      owner_idx_q    <= '0;
      owner_valid_q  <= 1'b0;
      my_turn_q      <= '0;
      win_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      err_protocol_q <= 1'b0;
      err_hold_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      owner_idx_q    <= owner_idx_d;
      owner_valid_q  <= owner_valid_d;
      my_turn_q      <= my_turn_d;
      win_cnt_q      <= win_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      err_protocol_q <= err_protocol_d;
      err_hold_q     <= err_hold_d;
    end
  end

  assign bus.my_turn       = my_turn_q;
  assign owner_valid       = owner_valid_q;
  assign owner_idx         = owner_idx_q;
  assign err_protocol      = err_protocol_q;
  assign err_hold_timeout  = err_hold_q;

  trn_tx_mux #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_mux (
    .sel                 (owner_idx_q),
    .sel_valid           (owner_valid_q),
    .req_td              (bus.req_trn_td),
    .req_trem_n          (bus.req_trn_trem_n),
    .req_tsof_n          (bus.req_trn_tsof_n),
    .req_teof_n          (bus.req_trn_teof_n),
    .req_tsrc_rdy_n      (bus.req_trn_tsrc_rdy_n),
    .req_cfg_interrupt_n (bus.req_cfg_interrupt_n),
    .td                  (bus.trn_td),
    .trem_n              (bus.trn_trem_n),
    .tsof_n              (bus.trn_tsof_n),
    .teof_n              (bus.trn_teof_n),
    .tsrc_rdy_n          (bus.trn_tsrc_rdy_n),
    .cfg_interrupt_n     (bus.cfg_interrupt_n)
  );

endmodule

// File: tb/tb_tx_trn_arbiter.sv
// Directed bench for tx_trn_arbiter: turn rotation, ownership, protocol errors, hold timeout, reset.
module tb_tx_trn_arbiter;

  localparam int NUM_REQ = 3;

  logic       trn_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       owner_valid;
  logic [1:0] owner_idx;
  logic       err_protocol;
  logic       err_hold_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  tx_trn_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  tx_trn_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .IDX_W       (2),
    .TURN_WINDOW (4),
    .HOLD_MAX    (1024)
  ) dut (
    .trn_clk          (trn_clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .owner_valid      (owner_valid),
    .owner_idx        (owner_idx),
    .err_protocol     (err_protocol),
    .err_hold_timeout (err_hold_timeout)
  );

  always #5 trn_clk = ~trn_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge trn_clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.driving_interface   = '0;
    bus.req_trn_td          = '0;
    bus.req_trn_trem_n      = '1;
    bus.req_trn_tsof_n      = '1;
    bus.req_trn_teof_n      = '1;
    bus.req_trn_tsrc_rdy_n  = '1;
    bus.req_cfg_interrupt_n = '1;
  endtask

  task automatic drive_req(input int i, input logic [63:0] td, input logic sof_n,
                           input logic eof_n, input logic src_rdy_n);
    bus.req_trn_td[64*i +: 64]   = td;
    bus.req_trn_trem_n[8*i +: 8] = 8'h00;
    bus.req_trn_tsof_n[i]        = sof_n;
    bus.req_trn_teof_n[i]        = eof_n;
    bus.req_trn_tsrc_rdy_n[i]    = src_rdy_n;
  endtask

  logic [2:0] t1_exp [16] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                              3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                              3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                              3'b001};

  initial begin
    idle_reqs();

    // Reset state
    #12;
    chk("rst_my_turn", 64'(bus.my_turn), 64'h0);
    chk("rst_owner_valid", 64'(owner_valid), 64'h0);
    chk("rst_owner_idx", 64'(owner_idx), 64'h0);
    chk("rst_td", bus.trn_td, 64'h0);
    chk("rst_trem", 64'(bus.trn_trem_n), 64'hFF);
    chk("rst_src_rdy", 64'(bus.trn_tsrc_rdy_n), 64'h1);
    chk("rst_sof", 64'(bus.trn_tsof_n), 64'h1);
    chk("rst_cfg_int", 64'(bus.cfg_interrupt_n), 64'h1);
    chk("rst_err_prot", 64'(err_protocol), 64'h0);
    chk("rst_err_hold", 64'(err_hold_timeout), 64'h0);
    #1 reset_n = 1'b1;

    // 1: rotation with no claims
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      chk($sformatf("rot_my_turn_%0d", k), 64'(bus.my_turn), 64'(t1_exp[k]));
    end

    // 2: req0 claims two cycles after its offer, sends three beats
    cyc(1);
    bus.driving_interface = 3'b001;
    drive_req(0, 64'hA5A5_A5A5_0000_0001, 1'b0, 1'b1, 1'b0);
    #1 chk("pre_own_td_idle", bus.trn_td, 64'h0);
    cyc(1);
    chk("own0_valid", 64'(owner_valid), 64'h1);
    chk("own0_idx", 64'(owner_idx), 64'h0);
    chk("own0_my_turn", 64'(bus.my_turn), 64'h0);
    chk("beat0_td", bus.trn_td, 64'hA5A5_A5A5_0000_0001);
    chk("beat0_sof", 64'(bus.trn_tsof_n), 64'h0);
    chk("beat0_src_rdy", 64'(bus.trn_tsrc_rdy_n), 64'h0);
    cyc(1);
    drive_req(0, 64'hA5A5_A5A5_0000_0002, 1'b1, 1'b1, 1'b0);
    #1 chk("beat1_td", bus.trn_td, 64'hA5A5_A5A5_0000_0002);
    cyc(1);
    drive_req(0, 64'hA5A5_A5A5_0000_0003, 1'b1, 1'b0, 1'b0);
    #1 chk("beat2_td", bus.trn_td, 64'hA5A5_A5A5_0000_0003);
    chk("beat2_eof", 64'(bus.trn_teof_n), 64'h0);
    chk("beat2_trem", 64'(bus.trn_trem_n), 64'h00);
    cyc(1);
    idle_reqs();
    cyc(1);
    chk("gap_owner_valid", 64'(owner_valid), 64'h0);
    chk("gap_my_turn", 64'(bus.my_turn), 64'h0);
    chk("gap_trem", 64'(bus.trn_trem_n), 64'hFF);
    cyc(1);
    chk("offer_req1", 64'(bus.my_turn), 64'h2);

    // 3: req1 claim lands on the window-expiry cycle
    cyc(3);
    bus.driving_interface = 3'b010;
    cyc(1);
    chk("edge_claim_valid", 64'(owner_valid), 64'h1);
    chk("edge_claim_idx", 64'(owner_idx), 64'h1);
    chk("edge_claim_my_turn", 64'(bus.my_turn), 64'h0);
    bus.driving_interface = 3'b000;
    cyc(2);
    chk("after_req1_offer", 64'(bus.my_turn), 64'h4);

    // 4: req2 claims while req0 is offered
    cyc(4);
    chk("gap_before_req0", 64'(bus.my_turn), 64'h0);
    cyc(1);
    chk("offer_req0_again", 64'(bus.my_turn), 64'h1);
    bus.driving_interface = 3'b100;
    drive_req(2, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 1'b0);
    #1 chk("bad_claim_td_idle", bus.trn_td, 64'h0);
    chk("bad_claim_src_idle", 64'(bus.trn_tsrc_rdy_n), 64'h1);
    cyc(1);
    chk("err_protocol_set", 64'(err_protocol), 64'h1);
    chk("bad_claim_no_owner", 64'(owner_valid), 64'h0);
    chk("bad_claim_turn_w1", 64'(bus.my_turn), 64'h1);
    idle_reqs();
    cyc(1);
    chk("bad_claim_turn_w2", 64'(bus.my_turn), 64'h1);
    cyc(1);
    chk("bad_claim_turn_w3", 64'(bus.my_turn), 64'h1);
    cyc(1);
    chk("bad_claim_gap", 64'(bus.my_turn), 64'h0);
    cyc(1);
    chk("bad_claim_next_req1", 64'(bus.my_turn), 64'h2);
    chk("err_protocol_sticky", 64'(err_protocol), 64'h1);

    // 5a: req1 holds exactly HOLD_MAX cycles - no timeout
    bus.driving_interface = 3'b010;
    cyc(1);
    chk("hold1_idx", 64'(owner_idx), 64'h1);
    cyc(1023);
    bus.driving_interface = 3'b000;
    cyc(1);
    chk("hold1024_released", 64'(owner_valid), 64'h0);
    chk("hold1024_no_err", 64'(err_hold_timeout), 64'h0);
    cyc(1);
    chk("hold1024_next_offer", 64'(bus.my_turn), 64'h4);

    // 5b: req2 holds past HOLD_MAX - flag sets, ownership kept
    bus.driving_interface = 3'b100;
    cyc(1);
    cyc(1025);
    chk("hold_err_set", 64'(err_hold_timeout), 64'h1);
    chk("hold_still_owner", 64'(owner_valid), 64'h1);
    cyc(4);
    chk("hold_no_forced_release", 64'(owner_valid), 64'h1);
    chk("hold_owner_idx", 64'(owner_idx), 64'h2);

    // 6: reset in the middle of a TLP
    drive_req(2, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 1'b0);
    #1 chk("mid_tlp_src_rdy", 64'(bus.trn_tsrc_rdy_n), 64'h0);
    chk("mid_tlp_td", bus.trn_td, 64'h0123_4567_89AB_CDEF);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_src_rdy", 64'(bus.trn_tsrc_rdy_n), 64'h1);
    chk("async_rst_td", bus.trn_td, 64'h0);
    chk("async_rst_my_turn", 64'(bus.my_turn), 64'h0);
    chk("async_rst_owner", 64'(owner_valid), 64'h0);
    chk("async_rst_err_hold", 64'(err_hold_timeout), 64'h0);
    idle_reqs();
    cyc(2);
    #2 reset_n = 1'b1;
    cyc(1);
    chk("post_rst_offer", 64'(bus.my_turn), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
